traffic_phase_scheduler: RTL and testbench

- Phase sequencer for a two-approach intersection (A = main road, B = side road).
- Advances through green/yellow/all-red phases on a 1 Hz tick enable, keeps a two-digit BCD countdown of the remaining seconds, and shortens the current green when a pedestrian requests a crossing.
- Sits between the frequency divider (tick source) and the display block, which drives the lamps and the 7-segment decoders from this block's outputs.

---
 rtl/traffic_pkg.sv | 29 ++
 rtl/bcd_down_counter.sv | 21 ++
 rtl/traffic_phase_scheduler.sv | 134 +++++++++++++
 tb/tb_traffic_phase_scheduler.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared states, lamp/BCD constants and integer-to-BCD helper for the phase scheduler.
// FLASH exists only when TRAFFIC_NIGHT_FLASH_EN is defined.
package traffic_pkg;

    typedef enum logic [2:0] {
        A_GREEN  = 3'd0,
        A_YELLOW = 3'd1,
        CLR_AB   = 3'd2,
        B_GREEN  = 3'd3,
        B_YELLOW = 3'd4,
        CLR_BA   = 3'd5
`ifdef TRAFFIC_NIGHT_FLASH_EN
        , FLASH  = 3'd6
`endif
    } state_t;

    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [3:0] BCD_BLANK    = 4'hF;

    function automatic logic [7:0] to_bcd(input int v);
        logic [7:0] r;
        r[7:4] = 4'(v / 10);
        r[3:0] = 4'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// bcd_down_counter: two-digit BCD down counter, synchronous load beats decrement.
module bcd_down_counter #(
    parameter logic [7:0] INIT = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       dec,
    output logic [7:0] count
);

    always_ff @(posedge clock or negedge reset)
        if (!reset)
            count <= INIT;
        else if (load)
            count <= load_val;
        else if (dec)
            count <= (count[3:0] == 4'd0) ? {count[7:4] - 4'd1, 4'd9} : {count[7:4], count[3:0] - 4'd1};

endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: two-approach phase sequencer with BCD countdown and pedestrian green cut.
// Define TRAFFIC_NIGHT_FLASH_EN to add night_mode and the flashing-yellow FLASH state.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int GREEN_TIME   = 25,
    parameter int YELLOW_TIME  = 3,
    parameter int ALLRED_TIME  = 2,
    parameter int PED_CUT_TIME = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       ped_req,
`ifdef TRAFFIC_NIGHT_FLASH_EN
    input  logic       night_mode,
`endif
    output logic [2:0] lightA,
    output logic [2:0] lightB,
    output logic [3:0] countTens,
    output logic [3:0] countOnes,
    output logic       ped_ack
);

    localparam logic [7:0] GREEN_BCD  = to_bcd(GREEN_TIME);
    localparam logic [7:0] YELLOW_BCD = to_bcd(YELLOW_TIME);
    localparam logic [7:0] ALLRED_BCD = to_bcd(ALLRED_TIME);
    localparam logic [7:0] CUT_BCD    = to_bcd(PED_CUT_TIME);

    generate
        if (PED_CUT_TIME < 1 || PED_CUT_TIME >= GREEN_TIME) begin : g_bad_cut
            $error("PED_CUT_TIME must satisfy 1 <= PED_CUT_TIME < GREEN_TIME");
        end
    endgenerate

    state_t     state, nxt;
    logic       pending, pend_n, ack_n, wrap, svc, cut, ld, dec, hold;
    logic [7:0] count, ld_val;
    logic [2:0] la_n, lb_n;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    logic       flash_on, flash_n;
`endif

    function automatic logic [7:0] phase_len(input state_t s);
        return (s == A_GREEN || s == B_GREEN) ? GREEN_BCD :
               (s == A_YELLOW || s == B_YELLOW) ? YELLOW_BCD :
               (s == CLR_AB || s == CLR_BA) ? ALLRED_BCD : {BCD_BLANK, BCD_BLANK};
    endfunction

    always_comb begin
        nxt    = state;
        hold   = 1'b0;
        pend_n = pending | ped_req;
`ifdef TRAFFIC_NIGHT_FLASH_EN
        flash_n = flash_on;
`endif
        wrap = tick && count == 8'h01;
        case (state)
            A_GREEN:  nxt = wrap ? A_YELLOW : A_GREEN;
            A_YELLOW: nxt = wrap ? CLR_AB : A_YELLOW;
            CLR_AB:   nxt = wrap ? B_GREEN : CLR_AB;
            B_GREEN:  nxt = wrap ? B_YELLOW : B_GREEN;
            B_YELLOW: nxt = wrap ? CLR_BA : B_YELLOW;
            CLR_BA: begin
`ifdef TRAFFIC_NIGHT_FLASH_EN
                nxt     = wrap ? (night_mode ? FLASH : A_GREEN) : CLR_BA;
                flash_n = 1'b0;
`else
                nxt = wrap ? A_GREEN : CLR_BA;
`endif
            end
`ifdef TRAFFIC_NIGHT_FLASH_EN
            FLASH: begin
                nxt     = (tick && !night_mode) ? CLR_BA : FLASH;
                flash_n = flash_on ^ (tick & night_mode);
                pend_n  = 1'b0;
                hold    = 1'b1;
            end
`endif
            default:  nxt = CLR_BA;
        endcase
        // Phase change outranks a pending cut; the new green services it a cycle later.
        svc    = (state == A_GREEN || state == B_GREEN) && pending && !wrap;
        ack_n  = svc;
        pend_n = svc ? ped_req : pend_n;
        cut    = svc && count > CUT_BCD;
        ld     = (nxt != state) || cut;
        ld_val = cut ? CUT_BCD : phase_len(nxt);
        dec    = tick && !svc && !hold;
        case (nxt)
            A_GREEN:  {la_n, lb_n} = {LIGHT_GREEN, LIGHT_RED};
            A_YELLOW: {la_n, lb_n} = {LIGHT_YELLOW, LIGHT_RED};
            B_GREEN:  {la_n, lb_n} = {LIGHT_RED, LIGHT_GREEN};
            B_YELLOW: {la_n, lb_n} = {LIGHT_RED, LIGHT_YELLOW};
`ifdef TRAFFIC_NIGHT_FLASH_EN
            FLASH:    {la_n, lb_n} = flash_n ? {LIGHT_YELLOW, LIGHT_YELLOW} : 6'b0;
`endif
            default:  {la_n, lb_n} = {LIGHT_RED, LIGHT_RED};
        endcase
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state    <= CLR_BA;
            pending  <= 1'b0;
            ped_ack  <= 1'b0;
            lightA   <= LIGHT_RED;
            lightB   <= LIGHT_RED;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            flash_on <= 1'b0;
`endif
        end else begin
            state    <= nxt;
            pending  <= pend_n;
            ped_ack  <= ack_n;
            lightA   <= la_n;
            lightB   <= lb_n;
`ifdef TRAFFIC_NIGHT_FLASH_EN
            flash_on <= flash_n;
`endif
        end

    bcd_down_counter #(.INIT(ALLRED_BCD)) u_cnt (
        .clock    (clock),
        .reset    (reset),
        .load     (ld),
        .load_val (ld_val),
        .dec      (dec),
        .count    (count)
    );

    assign {countTens, countOnes} = count;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb_traffic_phase_scheduler: directed self-checking bench for traffic_phase_scheduler.
module tb_traffic_phase_scheduler;
    import traffic_pkg::*;

    localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, O = 3'b000;
    localparam int LEN [6] = '{25, 3, 2, 25, 3, 2};
    localparam logic [5:0] LAMP [6] = '{{G, R}, {Y, R}, {R, R}, {R, G}, {R, Y}, {R, R}};

    logic clock = 1'b0, reset = 1'b0, tick = 1'b0, ped_req = 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
    logic night_mode = 1'b0;
`endif
    logic [2:0] lightA, lightB;
    logic [3:0] countTens, countOnes;
    logic ped_ack;
    logic [14:0] obs;
    int checks = 0, errors = 0;

    assign obs = {lightA, lightB, countTens, countOnes, ped_ack};

    traffic_phase_scheduler dut (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick),
        .ped_req   (ped_req),
`ifdef TRAFFIC_NIGHT_FLASH_EN
        .night_mode(night_mode),
`endif
        .lightA    (lightA),
        .lightB    (lightB),
        .countTens (countTens),
        .countOnes (countOnes),
        .ped_ack   (ped_ack)
    );

    always #5 clock = ~clock;

    // One posedge with the given inputs; returns at the following negedge.
    task automatic step(input logic t, input logic p);
        tick = t;
        ped_req = p;
        @(negedge clock);
        tick = 1'b0;
        ped_req = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if (obs !== {R, R, 8'h02, 1'b0}) begin errors++; $display("FAIL reset_hold: got %h want %h", obs, {R, R, 8'h02, 1'b0}); end
        reset = 1'b1;
        step(1'b0, 1'b0);
        checks++;
        if (obs !== {R, R, 8'h02, 1'b0}) begin errors++; $display("FAIL reset_release: got %h want %h", obs, {R, R, 8'h02, 1'b0}); end
    endtask

    task automatic test_sequence;
        int idx = 5, cnt = 2;
        logic [14:0] exp;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0);
            if (cnt == 1) begin
                idx = (idx + 1) % 6;
                cnt = LEN[idx];
            end else
                cnt--;
            exp = {LAMP[idx], 4'(cnt / 10), 4'(cnt % 10), 1'b0};
            checks++;
            if (obs !== exp) begin errors++; $display("FAIL sequence tick %0d: got %h want %h", i + 1, obs, exp); end
        end
    endtask

    task automatic test_ped_tick_same;
        repeat (5) step(1'b1, 1'b0);
        checks++;
        if (obs !== {R, G, 8'h12, 1'b0}) begin errors++; $display("FAIL bgreen_12: got %h want %h", obs, {R, G, 8'h12, 1'b0}); end
        step(1'b1, 1'b1);
        step(1'b1, 1'b0);
        checks++;
        if (obs !== {R, G, 8'h05, 1'b1}) begin errors++; $display("FAIL cut_with_tick: got %h want %h", obs, {R, G, 8'h05, 1'b1}); end
        step(1'b0, 1'b0);
        checks++;
        if (obs !== {R, G, 8'h05, 1'b0}) begin errors++; $display("FAIL ack_one_cycle: got %h want %h", obs, {R, G, 8'h05, 1'b0}); end
    endtask

    task automatic test_ped_yellow;
        repeat (5) step(1'b1, 1'b0);
        checks++;
        if (obs !== {R, Y, 8'h03, 1'b0}) begin errors++; $display("FAIL byellow_entry: got %h want %h", obs, {R, Y, 8'h03, 1'b0}); end
        step(1'b0, 1'b1);
        checks++;
        if (obs !== {R, Y, 8'h03, 1'b0}) begin errors++; $display("FAIL yellow_no_ack: got %h want %h", obs, {R, Y, 8'h03, 1'b0}); end
        repeat (3) step(1'b1, 1'b0);
        checks++;
        if (obs !== {R, R, 8'h02, 1'b0}) begin errors++; $display("FAIL clr_no_ack: got %h want %h", obs, {R, R, 8'h02, 1'b0}); end
        repeat (2) step(1'b1, 1'b0);
        checks++;
        if (obs !== {G, R, 8'h25, 1'b0}) begin errors++; $display("FAIL green_entry_held: got %h want %h", obs, {G, R, 8'h25, 1'b0}); end
        step(1'b0, 1'b0);
        checks++;
        if (obs !== {G, R, 8'h05, 1'b1}) begin errors++; $display("FAIL held_cut: got %h want %h", obs, {G, R, 8'h05, 1'b1}); end
        step(1'b0, 1'b0);
        checks++;
        if (obs !== {G, R, 8'h05, 1'b0}) begin errors++; $display("FAIL held_ack_drop: got %h want %h", obs, {G, R, 8'h05, 1'b0}); end
    endtask

    task automatic test_ped_at_cut;
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        checks++;
        if (obs !== {G, R, 8'h05, 1'b1}) begin errors++; $display("FAIL no_cut_at_05: got %h want %h", obs, {G, R, 8'h05, 1'b1}); end
    endtask

    task automatic test_reset_mid;
        repeat (10) step(1'b1, 1'b0);
        checks++;
        if (obs !== {R, G, 8'h25, 1'b0}) begin errors++; $display("FAIL bgreen_25: got %h want %h", obs, {R, G, 8'h25, 1'b0}); end
        repeat (16) step(1'b1, 1'b0);
        checks++;
        if (obs !== {R, G, 8'h09, 1'b0}) begin errors++; $display("FAIL bgreen_09: got %h want %h", obs, {R, G, 8'h09, 1'b0}); end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (obs !== {R, R, 8'h02, 1'b0}) begin errors++; $display("FAIL async_reset: got %h want %h", obs, {R, R, 8'h02, 1'b0}); end
        @(negedge clock);
        reset = 1'b1;
        step(1'b1, 1'b0);
        checks++;
        if (obs !== {R, R, 8'h01, 1'b0}) begin errors++; $display("FAIL post_reset_dec: got %h want %h", obs, {R, R, 8'h01, 1'b0}); end
        step(1'b1, 1'b0);
        checks++;
        if (obs !== {G, R, 8'h25, 1'b0}) begin errors++; $display("FAIL post_reset_agreen: got %h want %h", obs, {G, R, 8'h25, 1'b0}); end
    endtask

    task automatic test_ped_cut;
        repeat (7) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        checks++;
        if (obs !== {G, R, 8'h18, 1'b0}) begin errors++; $display("FAIL agreen_18: got %h want %h", obs, {G, R, 8'h18, 1'b0}); end
        step(1'b0, 1'b0);
        checks++;
        if (obs !== {G, R, 8'h05, 1'b1}) begin errors++; $display("FAIL cut_18_to_05: got %h want %h", obs, {G, R, 8'h05, 1'b1}); end
        step(1'b0, 1'b0);
        checks++;
        if (obs !== {G, R, 8'h05, 1'b0}) begin errors++; $display("FAIL cut_ack_drop: got %h want %h", obs, {G, R, 8'h05, 1'b0}); end
        step(1'b1, 1'b0);
        checks++;
        if (obs !== {G, R, 8'h04, 1'b0}) begin errors++; $display("FAIL after_cut_tick: got %h want %h", obs, {G, R, 8'h04, 1'b0}); end
    endtask

    task automatic test_back_to_back;
        repeat (2) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        checks++;
        if (obs !== {G, R, 8'h01, 1'b0}) begin errors++; $display("FAIL agreen_01: got %h want %h", obs, {G, R, 8'h01, 1'b0}); end
        step(1'b1, 1'b0);
        checks++;
        if (obs !== {Y, R, 8'h03, 1'b0}) begin errors++; $display("FAIL wrap_beats_pending: got %h want %h", obs, {Y, R, 8'h03, 1'b0}); end
        step(1'b0, 1'b0);
        checks++;
        if (obs !== {Y, R, 8'h03, 1'b0}) begin errors++; $display("FAIL yellow_pending_held: got %h want %h", obs, {Y, R, 8'h03, 1'b0}); end
    endtask

`ifdef TRAFFIC_NIGHT_FLASH_EN
    task automatic test_flash;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        night_mode = 1'b1;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        checks++;
        if (obs !== {O, O, 8'hFF, 1'b0}) begin errors++; $display("FAIL flash_entry: got %h want %h", obs, {O, O, 8'hFF, 1'b0}); end
        step(1'b1, 1'b0);
        checks++;
        if (obs !== {Y, Y, 8'hFF, 1'b0}) begin errors++; $display("FAIL flash_on: got %h want %h", obs, {Y, Y, 8'hFF, 1'b0}); end
        step(1'b0, 1'b1);
        checks++;
        if (obs !== {Y, Y, 8'hFF, 1'b0}) begin errors++; $display("FAIL flash_ped_ignored: got %h want %h", obs, {Y, Y, 8'hFF, 1'b0}); end
        step(1'b1, 1'b0);
        checks++;
        if (obs !== {O, O, 8'hFF, 1'b0}) begin errors++; $display("FAIL flash_off: got %h want %h", obs, {O, O, 8'hFF, 1'b0}); end
        night_mode = 1'b0;
        step(1'b1, 1'b0);
        checks++;
        if (obs !== {R, R, 8'h02, 1'b0}) begin errors++; $display("FAIL flash_exit: got %h want %h", obs, {R, R, 8'h02, 1'b0}); end
        repeat (2) step(1'b1, 1'b0);
        checks++;
        if (obs !== {G, R, 8'h25, 1'b0}) begin errors++; $display("FAIL flash_to_green: got %h want %h", obs, {G, R, 8'h25, 1'b0}); end
        step(1'b0, 1'b0);
        checks++;
        if (obs !== {G, R, 8'h25, 1'b0}) begin errors++; $display("FAIL flash_pending_cleared: got %h want %h", obs, {G, R, 8'h25, 1'b0}); end
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_ped_tick_same();
        test_ped_yellow();
        test_ped_at_cut();
        test_reset_mid();
        test_ped_cut();
        test_back_to_back();
`ifdef TRAFFIC_NIGHT_FLASH_EN
        test_flash();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
